// File: rtl/ucode_fetch_sequencer_if.sv
// Decode-to-fetch control bundle for the microcode sequencer.
// Decode side (valid/stall/instr/pc) flows into the sequencer; fetch controls flow out.
// master = core top level, slave = sequencer.
interface ucode_fetch_sequencer_if #(
  parameter int XLEN = 32
);
  // decode stage view
  logic            valid_d;
  logic            stall_d;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;

  // fetch/control outputs
  logic            start_matmul2;
  logic            start_matmul3;
  logic            end_matmul;
  logic            save_pc;
  logic            reset_pc;
  logic            pc_mux_sel;
  logic [XLEN-1:0] pc_backup;
  logic [1:0]      im_sel;
  logic            flush_fd;
  logic [1:0]      state;
  logic            illegal_seq;
  logic            wd_timeout;

  modport master (
    output valid_d, stall_d, instr_d, pc_d,
    input  start_matmul2, start_matmul3, end_matmul, save_pc, reset_pc,
           pc_mux_sel, pc_backup, im_sel, flush_fd, state, illegal_seq, wd_timeout
  );

  modport slave (
    input  valid_d, stall_d, instr_d, pc_d,
    output start_matmul2, start_matmul3, end_matmul, save_pc, reset_pc,
           pc_mux_sel, pc_backup, im_sel, flush_fd, state, illegal_seq, wd_timeout
  );
endinterface

// File: rtl/ucode_fetch_sequencer.sv
// Enters/leaves MATMUL microcode programs: saves return PC, switches IM, drives fetch mux and F/D flush.
// Latency: pulses are combinational in the hit cycle; state/im_sel/pc_backup update at the next edge.
// Backpressure: stall_d suppresses every hit; a held instruction fires once in its first unstalled cycle.
module ucode_fetch_sequencer #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] UPC_RESET   = '0,
  parameter int              MAX_UCYCLES = 1024,
  parameter int              WD_W        = 16
) (
  input logic                   clk,
  input logic                   reset,
  ucode_fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_NORMAL = 2'b00,
    S_MM2    = 2'b01,
    S_MM3    = 2'b10
  } state_t;

  localparam logic [6:0]      OP_START2 = 7'b1111010;
  localparam logic [6:0]      OP_START3 = 7'b1111011;
  localparam logic [6:0]      OP_END    = 7'b1111100;
  localparam logic [1:0]      IM_NORMAL = 2'b00;
  localparam logic [1:0]      IM_MM2    = 2'b01;
  localparam logic [1:0]      IM_MM3    = 2'b10;
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(MAX_UCYCLES - 1);

  state_t          state_q, state_n;
  logic [1:0]      im_sel_q, im_sel_n;
  logic [XLEN-1:0] pc_backup_q, pc_backup_n;
  logic [WD_W-1:0] wd_q, wd_n;

  logic qual, hit_mm2, hit_mm3, hit_end, wd_expire;
  logic start_matmul2, start_matmul3, end_matmul, save_pc, reset_pc;
  logic pc_mux_sel, flush_fd, illegal_seq, wd_timeout;

  // The ROM entry address itself is applied by fetch; only the upper opcode bits are don't-care here.
  logic unused_bits;
  assign unused_bits = ^{bus.instr_d[31:7], UPC_RESET};

  assign qual      = bus.valid_d & ~bus.stall_d;
  assign hit_mm2   = qual & (bus.instr_d[6:0] == OP_START2);
  assign hit_mm3   = qual & (bus.instr_d[6:0] == OP_START3);
  assign hit_end   = qual & (bus.instr_d[6:0] == OP_END);
  assign wd_expire = (state_q != S_NORMAL) && (wd_q == WD_LAST);

  // State, IM select, return PC and watchdog registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_NORMAL;
      im_sel_q    <= IM_NORMAL;
      pc_backup_q <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_n;
      im_sel_q    <= im_sel_n;
      pc_backup_q <= pc_backup_n;
      wd_q        <= wd_n;
    end
  end

  // Next-state and pulse decode: entry from NORMAL, exit on END or watchdog, illegal nesting flagged.
  always_comb begin
    state_n       = state_q;
    im_sel_n      = im_sel_q;
    pc_backup_n   = pc_backup_q;
    wd_n          = wd_q;
    start_matmul2 = 1'b0;
    start_matmul3 = 1'b0;
    end_matmul    = 1'b0;
    save_pc       = 1'b0;
    reset_pc      = 1'b0;
    pc_mux_sel    = 1'b1;
    flush_fd      = 1'b0;
    illegal_seq   = 1'b0;
    wd_timeout    = 1'b0;

    case (state_q)
      S_NORMAL: begin
        wd_n = '0;
        if (hit_mm2 || hit_mm3) begin
          start_matmul2 = hit_mm2;
          start_matmul3 = hit_mm3;
          save_pc       = 1'b1;
          reset_pc      = 1'b1;
          flush_fd      = 1'b1;
          state_n       = hit_mm2 ? S_MM2 : S_MM3;
          im_sel_n      = hit_mm2 ? IM_MM2 : IM_MM3;
          pc_backup_n   = bus.pc_d + XLEN'(4);
        end else if (hit_end) begin
          illegal_seq = 1'b1;
        end
      end

      S_MM2, S_MM3: begin
        // Nested START is ignored; it can coincide with an END/timeout in the same cycle.
        illegal_seq = hit_mm2 | hit_mm3;
        if (hit_end || wd_expire) begin
          // A real END wins over the watchdog, so wd_timeout only flags a forced return.
          end_matmul = 1'b1;
          wd_timeout = ~hit_end;
          pc_mux_sel = 1'b0;
          flush_fd   = 1'b1;
          state_n    = S_NORMAL;
          im_sel_n   = IM_NORMAL;
          wd_n       = '0;
        end else begin
          // wd_q < WD_LAST here, so the increment is inherently saturating.
          wd_n = wd_q + WD_W'(1);
        end
      end

      default: begin
        state_n  = S_NORMAL;
        im_sel_n = IM_NORMAL;
        wd_n     = '0;
      end
    endcase
  end

  assign bus.start_matmul2 = start_matmul2;
  assign bus.start_matmul3 = start_matmul3;
  assign bus.end_matmul    = end_matmul;
  assign bus.save_pc       = save_pc;
  assign bus.reset_pc      = reset_pc;
  assign bus.pc_mux_sel    = pc_mux_sel;
  assign bus.pc_backup     = pc_backup_q;
  assign bus.im_sel        = im_sel_q;
  assign bus.flush_fd      = flush_fd;
  assign bus.state         = state_q;
  assign bus.illegal_seq   = illegal_seq;
  assign bus.wd_timeout    = wd_timeout;

endmodule

// File: tb/tb_ucode_fetch_sequencer.sv
// Bench for ucode_fetch_sequencer: scoreboard of expected per-cycle outputs plus directed checks.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// MAX_UCYCLES is 8 so the watchdog is reachable in a few cycles.
module tb_ucode_fetch_sequencer;

  localparam int         MAXU = 8;
  localparam logic [6:0] OP2  = 7'b1111010;
  localparam logic [6:0] OP3  = 7'b1111011;
  localparam logic [6:0] OPE  = 7'b1111100;
  localparam logic [6:0] OPN  = 7'b0010011;

  typedef struct packed {
    logic [1:0]  state;
    logic [1:0]  im_sel;
    logic [31:0] pc_backup;
    logic        pc_mux_sel;
    logic        start2;
    logic        start3;
    logic        endm;
    logic        save;
    logic        rst_pc;
    logic        flush;
    logic        illegal;
    logic        wdt;
  } obs_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  obs_t sb[$];

  ucode_fetch_sequencer_if #(.XLEN(32)) bus ();

  ucode_fetch_sequencer #(
    .XLEN(32), .UPC_RESET(32'h0), .MAX_UCYCLES(MAXU), .WD_W(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [1:0]  m_state;
  logic [31:0] m_backup;
  int          m_wd;

  function automatic logic [2:0] model_hits();
    logic q;
    q = bus.valid_d && !bus.stall_d;
    return {q && bus.instr_d[6:0] == OPE, q && bus.instr_d[6:0] == OP3, q && bus.instr_d[6:0] == OP2};
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    logic [2:0] h;
    h = model_hits();
    o = '0;
    o.state      = m_state;
    o.im_sel     = m_state;
    o.pc_backup  = m_backup;
    o.pc_mux_sel = 1'b1;
    if (m_state == 2'b00) begin
      if (h[0] || h[1]) begin
        o.start2 = h[0];
        o.start3 = h[1];
        o.save   = 1'b1;
        o.rst_pc = 1'b1;
        o.flush  = 1'b1;
      end else if (h[2]) begin
        o.illegal = 1'b1;
      end
    end else begin
      o.illegal = h[0] | h[1];
      if (h[2] || m_wd == MAXU - 1) begin
        o.endm       = 1'b1;
        o.pc_mux_sel = 1'b0;
        o.flush      = 1'b1;
        o.wdt        = !h[2];
      end
    end
    return o;
  endfunction

  // Model register update
  always @(posedge clk) begin
    logic [2:0] h;
    h = model_hits();
    if (!reset) begin
      m_state  <= 2'b00;
      m_backup <= 32'h0;
      m_wd     <= 0;
    end else if (m_state == 2'b00) begin
      if (h[0] || h[1]) begin
        m_state  <= h[0] ? 2'b01 : 2'b10;
        m_backup <= bus.pc_d + 32'd4;
        m_wd     <= 0;
      end
    end else if (h[2] || m_wd == MAXU - 1) begin
      m_state <= 2'b00;
      m_wd    <= 0;
    end else begin
      m_wd <= m_wd + 1;
    end
  end

  function automatic logic [31:0] mk(input logic [6:0] op);
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], op};
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state      = bus.state;
    o.im_sel     = bus.im_sel;
    o.pc_backup  = bus.pc_backup;
    o.pc_mux_sel = bus.pc_mux_sel;
    o.start2     = bus.start_matmul2;
    o.start3     = bus.start_matmul3;
    o.endm       = bus.end_matmul;
    o.save       = bus.save_pc;
    o.rst_pc     = bus.reset_pc;
    o.flush      = bus.flush_fd;
    o.illegal    = bus.illegal_seq;
    o.wdt        = bus.wd_timeout;
    return o;
  endfunction

  // Apply one cycle of stimulus and queue the expected outputs for it.
  task automatic drive(input logic rst, input logic v, input logic s, input logic [31:0] ins,
                       input logic [31:0] pc);
    reset       = rst;
    bus.valid_d = v;
    bus.stall_d = s;
    bus.instr_d = ins;
    bus.pc_d    = pc;
    sb.push_back(model_out());
  endtask

  task automatic test_reset();
    obs_t got, exp;
    drive(1'b0, 1'b0, 1'b0, mk(OPN), 32'h0);
    @(posedge clk); #1;
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(i == 2, 1'b0, 1'b0, mk(OPN), 32'h0);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_sb got=%h exp=%h", got, exp); end
      checks++;
      if (got !== obs_t'({2'b00, 2'b00, 32'h0, 1'b1, 8'h00})) begin
        errors++; $display("FAIL reset_state got=%h exp=%h", got, obs_t'({2'b00, 2'b00, 32'h0, 1'b1, 8'h00}));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start2();
    obs_t got, exp;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, i == 0, 1'b0, mk(i == 0 ? OP2 : OPN), 32'h10);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL start2_sb got=%h exp=%h", got, exp); end
      checks++;
      if (i == 0 && {got.start2, got.save, got.rst_pc, got.flush, got.start3} !== 5'b11110) begin
        errors++; $display("FAIL start2_pulses got=%b exp=11110", {got.start2, got.save, got.rst_pc, got.flush, got.start3});
      end else if (i == 1 && {got.state, got.im_sel, got.pc_backup} !== {2'b01, 2'b01, 32'h14}) begin
        errors++; $display("FAIL start2_entered got=%h exp=%h", {got.state, got.im_sel, got.pc_backup}, {2'b01, 2'b01, 32'h14});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_end();
    obs_t got, exp;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, i == 0, 1'b0, mk(i == 0 ? OPE : OPN), 32'h200);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL end_sb got=%h exp=%h", got, exp); end
      checks++;
      if (i == 0 && {got.endm, got.pc_mux_sel, got.flush, got.pc_backup} !== {1'b1, 1'b0, 1'b1, 32'h14}) begin
        errors++; $display("FAIL end_pulses got=%h exp=%h", {got.endm, got.pc_mux_sel, got.flush, got.pc_backup}, {1'b1, 1'b0, 1'b1, 32'h14});
      end else if (i == 1 && {got.state, got.im_sel, got.pc_mux_sel} !== 5'b00001) begin
        errors++; $display("FAIL end_returned got=%b exp=00001", {got.state, got.im_sel, got.pc_mux_sel});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    obs_t got, exp;
    logic [31:0] ins;
    int pulses;
    pulses = 0;
    ins = mk(OP3);
    for (int i = 0; i < 6; i++) begin
      // 3 stalled cycles, release, one idle resident cycle, then END
      if (i < 4) drive(1'b1, 1'b1, i < 3, ins, 32'h300);
      else drive(1'b1, i == 5, 1'b0, mk(i == 5 ? OPE : OPN), 32'h0);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_sb step=%0d got=%h exp=%h", i, got, exp); end
      if (got.start3 === 1'b1) pulses++;
      if (i == 4) begin
        checks++;
        if (got.im_sel !== 2'b10 || got.pc_backup !== 32'h304) begin
          errors++; $display("FAIL stall_entered got=%h/%h exp=2/00000304", got.im_sel, got.pc_backup);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL stall_pulse_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_illegal();
    obs_t got, exp;
    logic [6:0] ops [6];
    ops = '{OP2, OP2, OP3, OPE, OPE, OPN};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, mk(ops[i]), 32'h100 + 32'(i * 16));
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL illegal_sb step=%0d got=%h exp=%h", i, got, exp); end
      if (i == 1 || i == 2) begin
        checks++;
        if ({got.illegal, got.state, got.pc_backup, got.start2, got.start3} !== {1'b1, 2'b01, 32'h104, 2'b00}) begin
          errors++; $display("FAIL illegal_nested step=%0d got=%h", i, {got.illegal, got.state, got.pc_backup});
        end
      end
      if (i == 4) begin
        checks++;
        if ({got.illegal, got.endm, got.pc_mux_sel, got.flush, got.state} !== 6'b101000) begin
          errors++; $display("FAIL illegal_stray_end got=%b exp=101000", {got.illegal, got.endm, got.pc_mux_sel, got.flush, got.state});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bubble();
    obs_t got, exp;
    logic [6:0] ops [3];
    ops = '{OP2, OP3, OPE};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, mk(ops[i]), 32'h40);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL bubble_sb got=%h exp=%h", got, exp); end
      @(posedge clk); #1;
    end
  endtask

  // Enter at the top of the address space, then either let the watchdog fire or END on its last cycle.
  task automatic test_watchdog(input logic end_on_last);
    obs_t got, exp;
    for (int i = 0; i <= MAXU + 1; i++) begin
      if (i == 0) drive(1'b1, 1'b1, 1'b0, mk(OP2), 32'hFFFF_FFFC);
      else if (i >= 2 && i <= 4) drive(1'b1, 1'b1, 1'b1, mk(OPE), 32'h0);
      else drive(1'b1, i == MAXU && end_on_last, 1'b0, mk(i == MAXU ? OPE : OPN), 32'h0);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL wd_sb end=%0b step=%0d got=%h exp=%h", end_on_last, i, got, exp); end
      if (i == MAXU) begin
        checks++;
        if ({got.wdt, got.endm, got.pc_mux_sel, got.pc_backup} !== {!end_on_last, 1'b1, 1'b0, 32'h0}) begin
          errors++; $display("FAIL wd_last end=%0b got=%h exp=%h", end_on_last, {got.wdt, got.endm, got.pc_mux_sel, got.pc_backup}, {!end_on_last, 1'b1, 1'b0, 32'h0});
        end
      end else if (i == MAXU - 1) begin
        checks++;
        if ({got.endm, got.wdt, got.state} !== 4'b0001) begin
          errors++; $display("FAIL wd_early got=%b exp=0001", {got.endm, got.wdt, got.state});
        end
      end else if (i == MAXU + 1) begin
        checks++;
        if (got.state !== 2'b00) begin errors++; $display("FAIL wd_return got=%b exp=00", got.state); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_ucode();
    obs_t got, exp;
    for (int i = 0; i < 4; i++) begin
      drive(i != 2, i == 0, 1'b0, mk(i == 0 ? OP3 : OPN), 32'h40);
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_ucode_sb step=%0d got=%h exp=%h", i, got, exp); end
      if (i == 2) begin
        checks++;
        if (got.endm !== 1'b0 || got.state !== 2'b10) begin
          errors++; $display("FAIL rst_ucode_no_end got=%b/%b exp=0/10", got.endm, got.state);
        end
      end
      if (i == 3) begin
        checks++;
        if ({got.state, got.im_sel, got.pc_backup, got.endm} !== {4'b0000, 32'h0, 1'b0}) begin
          errors++; $display("FAIL rst_ucode_cleared got=%h", {got.state, got.im_sel, got.pc_backup, got.endm});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    obs_t got, exp;
    logic [6:0] op;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: op = OP2;
        1: op = OP3;
        2, 3: op = OPE;
        default: op = OPN;
      endcase
      drive(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, mk(op), $urandom());
      @(negedge clk);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL random_sb step=%0d got=%h exp=%h", i, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.valid_d = 1'b0;
    bus.stall_d = 1'b0;
    bus.instr_d = 32'h0;
    bus.pc_d    = 32'h0;
    test_reset();
    test_start2();
    test_end();
    test_stall();
    test_illegal();
    test_bubble();
    test_watchdog(1'b0);
    test_watchdog(1'b1);
    test_reset_in_ucode();
    test_random();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
